// File: rtl/debounce_bank.sv
// Bank of independent button debouncers with press/release edge pulses and auto-repeat.
// `release` is a reserved word, so the release pulse port is named rel.
`timescale 1ns/1ps

module debounce_lane #(
  parameter int CNT_W        = 10,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int INV_IN       = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic noisy,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic             INV        = (INV_IN != 0);
  localparam logic [CNT_W-1:0] ST_LAST    = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync;
  logic             s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, rcnt, rcnt_nx;
  logic             rphase, rphase_nx, rpt_nx, level_nx;

  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= '0;
    else        sync <= {sync[0], noisy ^ INV};

  assign s = sync[1];

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rcnt_nx   = rcnt;
    rphase_nx = rphase;
    rpt_nx    = 1'b0;
    case (state)
      RELEASED:
        if (s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      PRESS_WAIT:
        if (!s) state_nx = RELEASED;
        else if (tick) begin
          if (cnt == ST_LAST) begin
            state_nx  = PRESSED;
            rcnt_nx   = '0;
            rphase_nx = 1'b0;
          end else cnt_nx = cnt + 1'b1;
        end
      PRESSED:
        if (!s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end else if (!repeat_en) begin
          rcnt_nx   = '0;
          rphase_nx = 1'b0;
        end else if (tick) begin
          // rphase=0 waits out the initial delay, rphase=1 runs at the repeat rate
          if (rcnt == (rphase ? RATE_LAST : DELAY_LAST)) begin
            rpt_nx    = 1'b1;
            rcnt_nx   = '0;
            rphase_nx = 1'b1;
          end else rcnt_nx = rcnt + 1'b1;
        end
      RELEASE_WAIT:
        if (s) state_nx = PRESSED;
        else if (tick) begin
          if (cnt == ST_LAST) state_nx = RELEASED;
          else                cnt_nx   = cnt + 1'b1;
        end
      default: state_nx = RELEASED;
    endcase
  end

  assign level_nx = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= RELEASED;
      cnt    <= '0;
      rcnt   <= '0;
      rphase <= 1'b0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      rpt    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rcnt   <= rcnt_nx;
      rphase <= rphase_nx;
      level  <= level_nx;
      press  <= level_nx & ~level;
      rel    <= ~level_nx & level;
      rpt    <= rpt_nx;
    end
endmodule

module debounce_bank #(
  parameter int N_CH         = 5,
  parameter int CNT_W        = 10,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int INV_IN       = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [N_CH-1:0] noisy,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] rpt
);
  debounce_lane #(
    .CNT_W(CNT_W), .STABLE_TICKS(STABLE_TICKS), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .INV_IN(INV_IN)
  ) u_lane [N_CH-1:0] (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .noisy    (noisy),
    .repeat_en(repeat_en),
    .level    (level),
    .press    (press),
    .rel      (rel),
    .rpt      (rpt)
  );
endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- N_CH, 5: number of independent button channels.
- CNT_W, 10: width of the per-channel tick counters.
- STABLE_TICKS, 20: consecutive ticks an input must hold before a level change is accepted; range 1..2^CNT_W-1.
- REPEAT_DELAY, 500: ticks from press to the first auto-repeat pulse; range 1..2^CNT_W-1.
- REPEAT_RATE, 100: ticks between subsequent auto-repeat pulses; range 1..2^CNT_W-1.
- INV_IN, 0: when 1, raw inputs are active-low and are inverted before synchronisation.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single system clock; all logic is on its rising edge.
- reset, in, 1: asynchronous, active-low reset; assertion takes effect immediately, release is synchronous to clk.
- tick, in, 1: one-clk-wide timebase enable, nominally 1 kHz.
- noisy, in, N_CH: raw button inputs, asynchronous to clk.
- repeat_en, in, N_CH: per-channel auto-repeat enable, synchronous to clk.
- level, out, N_CH: debounced button state, 1 = pressed.
- press, out, N_CH: one-clk pulse when level rises.
- release, out, N_CH: one-clk pulse when level falls.
- rpt, out, N_CH: one-clk auto-repeat pulse while the button is held.

Function
REQ-003 Each noisy bit SHALL pass through a 2-flop synchroniser, after inversion if INV_IN=1, to give s[i]; all further logic SHALL use s[i] only.
REQ-004 Each channel SHALL run an independent FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, and a stability counter cnt of CNT_W bits.
REQ-005 RELEASED: if s=1, the FSM SHALL go to PRESS_WAIT and set cnt=0; otherwise it SHALL stay in RELEASED.
REQ-006 PRESS_WAIT: behaviour SHALL be:
- s=0: return to RELEASED, no pulse.
- s=1 and tick and cnt==STABLE_TICKS-1: go to PRESSED.
- s=1 and tick otherwise: increment cnt.
- no tick: hold.
REQ-007 PRESSED and RELEASE_WAIT SHALL mirror REQ-005 and REQ-006 with s inverted, and RELEASE_WAIT SHALL return to RELEASED on acceptance.
REQ-008 level SHALL be 1 exactly while the FSM is in PRESSED or RELEASE_WAIT, and SHALL be registered.
REQ-009 press (release) SHALL assert for exactly one clk, in the first cycle that level is 1 (0).
REQ-010 A glitch shorter than STABLE_TICKS ticks SHALL produce no level change and no pulse; a glitch SHALL reset cnt, never decrement it.
REQ-011 If s changes in the same cycle as the qualifying tick, s SHALL win: no acceptance, and the FSM returns to the previous stable state.
REQ-012 Auto-repeat SHALL use a per-channel counter rcnt (CNT_W bits), active only in PRESSED with repeat_en=1:
- rcnt is cleared on entry to PRESSED.
- rcnt increments on each tick.
- The first rpt pulse fires on the tick where rcnt reaches REPEAT_DELAY-1; rcnt then reloads to 0.
- Further rpt pulses fire every REPEAT_RATE ticks after that.
REQ-013 If repeat_en drops while PRESSED, rcnt and the first/subsequent phase SHALL clear, and no rpt pulse SHALL fire; on re-assertion, timing SHALL restart from REPEAT_DELAY.
REQ-014 RELEASE_WAIT SHALL freeze rcnt; a return to PRESSED SHALL resume from the frozen value.
REQ-015 rpt SHALL never assert in the same cycle as press or release for the same channel.
REQ-016 Counters SHALL never wrap: they compare for equality only and reload at their terminal value.
REQ-017 Channels SHALL share no state; simultaneous events on any subset of channels SHALL be handled independently in the same cycle.
REQ-018 Latency from a stable noisy edge to press/release SHALL be 2 clk (synchroniser) + 1 clk (FSM entry) + STABLE_TICKS ticks + 1 clk.

Reset
REQ-019 While reset=0, the block SHALL force:
- synchroniser flops, cnt and rcnt to 0;
- every FSM to RELEASED;
- level, press, release and rpt to all-zeros.
REQ-020 Reset asserted mid-debounce or mid-hold SHALL discard all progress and emit no pulse.
REQ-021 After reset release, a held button SHALL be re-debounced from RELEASED and produce a fresh press.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (N_CH=5, STABLE_TICKS=4, REPEAT_DELAY=6, REPEAT_RATE=3, tick every 10 clk):
- Clean press of noisy[0] held 100 clk -> level[0]=1 and a single press[0] pulse after the 4th tick; no activity on other channels.
- noisy[2] 1 for 25 clk (2 ticks) then 0 -> level[2] stays 0, and no press or release pulse.
- noisy[1] held 200 clk with repeat_en[1]=1 -> rpt[1] at tick 6 after press, then every 3 ticks; rpt never coincides with press.
- repeat_en[1] drops at tick 7 then re-asserts -> no rpt until 6 ticks after re-assertion.
- Simultaneous press on channels 0 and 4 -> both press pulses in the same cycle; release on channel 0 only -> release[0] alone.
- reset driven low during PRESS_WAIT and again during PRESSED -> all outputs 0 immediately; after release with button still held, exactly one new press after 4 ticks.
